pipelined_carry_select_adder: RTL and testbench

//   Parametrised, pipelined carry-select adder/subtractor with valid/ready flow control.

---
 rtl/pipelined_carry_select_adder.sv | 135 +++++++++++++
 tb/tb_pipelined_carry_select_adder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_select_adder.sv
// Carry-select adder/subtractor; BLOCK_WIDTH slices, carry chain cut into PIPE_STAGES register groups.
// Latency: PIPE_STAGES cycles from accept to valid_o, one operation per cycle.
// Backpressure: one global advance (!valid_o || ready_i); a stall freezes every stage and holds the outputs.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   valid_i / ready_o       input handshake; ready_o is the global advance enable
//   operand1_i, operand2_i  operands A and B
//   carry_i, sub_i          carry/borrow-in; sub_i=1 computes A-B-carry_i
//   valid_o / ready_i       output handshake
//   sum_o, carry_o          registered result and raw MSB carry-out (sub: 1 = no borrow)
//   overflow_o              registered signed overflow flag
module pipelined_carry_select_adder #(
    parameter int BIT_WIDTH   = 32,
    parameter int BLOCK_WIDTH = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [BIT_WIDTH-1:0] operand1_i,
    input  logic [BIT_WIDTH-1:0] operand2_i,
    input  logic                 carry_i,
    input  logic                 sub_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [BIT_WIDTH-1:0] sum_o,
    output logic                 carry_o,
    output logic                 overflow_o
);

    localparam int NUM_BLOCKS       = BIT_WIDTH / BLOCK_WIDTH;
    localparam int BLOCKS_PER_STAGE = (NUM_BLOCKS + PIPE_STAGES - 1) / PIPE_STAGES;
    localparam int MSB              = BIT_WIDTH - 1;

    if (BIT_WIDTH % BLOCK_WIDTH != 0) begin : g_bad_width
        $error("BIT_WIDTH must be a multiple of BLOCK_WIDTH");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > BIT_WIDTH / BLOCK_WIDTH) begin : g_bad_stages
        $error("PIPE_STAGES must be in 1..BIT_WIDTH/BLOCK_WIDTH");
    end

    // One pipeline word: operands (B already conditionally inverted), the partial sum
    // whose low slices are resolved so far, and the carry out of the resolved group.
    typedef struct packed {
        logic [BIT_WIDTH-1:0] a;
        logic [BIT_WIDTH-1:0] b;
        logic [BIT_WIDTH-1:0] s;
        logic                 c;
    } stage_t;

    stage_t                 stage_in [PIPE_STAGES];
    stage_t                 stage_d  [PIPE_STAGES];
    stage_t                 stage_q  [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] stage_vld;
    logic                   ovf_d;
    logic                   ovf_q;
    logic                   adv;

    // Resolves the slices owned by one stage. Slice 0 ripples straight from the
    // carry-in; every other slice precomputes both carry hypotheses and the incoming
    // carry only drives the select mux. Stages that own no slices pass the word through.
    function automatic stage_t resolve_stage(input int stage, input stage_t in_s);
        stage_t               out_s;
        logic                 carry;
        logic [BLOCK_WIDTH:0] sum0;
        logic [BLOCK_WIDTH:0] sum1;
        logic [BLOCK_WIDTH:0] sel;
        out_s = in_s;
        carry = in_s.c;
        for (int blk = 0; blk < NUM_BLOCKS; blk++) begin
            if ((blk >= stage * BLOCKS_PER_STAGE) && (blk < (stage + 1) * BLOCKS_PER_STAGE)) begin
                sum0 = {1'b0, in_s.a[blk*BLOCK_WIDTH +: BLOCK_WIDTH]}
                     + {1'b0, in_s.b[blk*BLOCK_WIDTH +: BLOCK_WIDTH]};
                sum1 = sum0 + {{BLOCK_WIDTH{1'b0}}, 1'b1};
                if (blk == 0) begin
                    sel = sum0 + {{BLOCK_WIDTH{1'b0}}, carry};
                end else begin
                    sel = carry ? sum1 : sum0;
                end
                out_s.s[blk*BLOCK_WIDTH +: BLOCK_WIDTH] = sel[BLOCK_WIDTH-1:0];
                carry = sel[BLOCK_WIDTH];
            end
        end
        out_s.c = carry;
        return out_s;
    endfunction

    always_comb begin
        // Subtraction is A + ~B + 1 with the borrow folded into the carry-in.
        stage_in[0].a = operand1_i;
        stage_in[0].b = sub_i ? ~operand2_i : operand2_i;
        stage_in[0].s = '0;
        stage_in[0].c = carry_i ^ sub_i;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            stage_in[k] = stage_q[k-1];
        end
        for (int k = 0; k < PIPE_STAGES; k++) begin
            stage_d[k] = resolve_stage(k, stage_in[k]);
        end
        // Same-sign operands producing a result of the other sign.
        ovf_d = (stage_in[PIPE_STAGES-1].a[MSB] == stage_in[PIPE_STAGES-1].b[MSB])
             && (stage_d[PIPE_STAGES-1].s[MSB] != stage_in[PIPE_STAGES-1].a[MSB]);
    end

    assign adv = !valid_o || ready_i;

    // Data registers are reset too so that sum_o reads zero out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_vld <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                stage_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            stage_vld[0] <= valid_i;
            for (int k = 1; k < PIPE_STAGES; k++) begin
                stage_vld[k] <= stage_vld[k-1];
            end
            for (int k = 0; k < PIPE_STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign ready_o    = adv;
    assign valid_o    = stage_vld[PIPE_STAGES-1];
    assign sum_o      = stage_q[PIPE_STAGES-1].s;
    assign carry_o    = stage_q[PIPE_STAGES-1].c;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Bench for pipelined_carry_select_adder: five instances with different slice/stage
// geometry share one input stream; each has its own expected-result queue.
// Instance 0 (4,2) also sees backpressure; the others always have ready_i=1.
module tb_pipelined_carry_select_adder;

    localparam int NDUT = 5;

    typedef struct {
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        carry_i;
    logic        sub_i;
    logic        rdy_main;
    logic        rdy_all;
    logic [31:0] op_a;
    logic [31:0] op_b;

    logic        rdy_o  [NDUT];
    logic        vld_o  [NDUT];
    logic [31:0] sum_w  [NDUT];
    logic        cout_w [NDUT];
    logic        ovf_w  [NDUT];

    exp_t sb [NDUT][$];
    bit   acc [NDUT];
    int   cyc;
    int   total;
    int   bad;
    bit   strict0;

    always #5 clk = ~clk;

    pipelined_carry_select_adder #(.BIT_WIDTH(32), .BLOCK_WIDTH(4), .PIPE_STAGES(2)) u_dut0 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(rdy_o[0]),
        .operand1_i(op_a), .operand2_i(op_b), .carry_i(carry_i), .sub_i(sub_i),
        .valid_o(vld_o[0]), .ready_i(rdy_main), .sum_o(sum_w[0]), .carry_o(cout_w[0]),
        .overflow_o(ovf_w[0]));

    pipelined_carry_select_adder #(.BIT_WIDTH(32), .BLOCK_WIDTH(4), .PIPE_STAGES(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(rdy_o[1]),
        .operand1_i(op_a), .operand2_i(op_b), .carry_i(carry_i), .sub_i(sub_i),
        .valid_o(vld_o[1]), .ready_i(rdy_all), .sum_o(sum_w[1]), .carry_o(cout_w[1]),
        .overflow_o(ovf_w[1]));

    pipelined_carry_select_adder #(.BIT_WIDTH(32), .BLOCK_WIDTH(4), .PIPE_STAGES(8)) u_dut2 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(rdy_o[2]),
        .operand1_i(op_a), .operand2_i(op_b), .carry_i(carry_i), .sub_i(sub_i),
        .valid_o(vld_o[2]), .ready_i(rdy_all), .sum_o(sum_w[2]), .carry_o(cout_w[2]),
        .overflow_o(ovf_w[2]));

    pipelined_carry_select_adder #(.BIT_WIDTH(32), .BLOCK_WIDTH(8), .PIPE_STAGES(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(rdy_o[3]),
        .operand1_i(op_a), .operand2_i(op_b), .carry_i(carry_i), .sub_i(sub_i),
        .valid_o(vld_o[3]), .ready_i(rdy_all), .sum_o(sum_w[3]), .carry_o(cout_w[3]),
        .overflow_o(ovf_w[3]));

    pipelined_carry_select_adder #(.BIT_WIDTH(32), .BLOCK_WIDTH(1), .PIPE_STAGES(1)) u_dut4 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(rdy_o[4]),
        .operand1_i(op_a), .operand2_i(op_b), .carry_i(carry_i), .sub_i(sub_i),
        .valid_o(vld_o[4]), .ready_i(rdy_all), .sum_o(sum_w[4]), .carry_o(cout_w[4]),
        .overflow_o(ovf_w[4]));

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            2:       return 8;
            3:       return 3;
            default: return 1;
        endcase
    endfunction

    // Reference: plain signed/unsigned arithmetic on 64-bit integers.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic c, input logic s);
        exp_t            r;
        longint          sa;
        longint          sbv;
        longint          res;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned uc;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        uc  = {63'd0, c};
        if (s) begin
            res     = sa - sbv - longint'(uc);
            r.carry = (ua >= ub + uc);
        end else begin
            res     = sa + sbv + longint'(uc);
            r.carry = ((ua + ub + uc) > 64'h0000_0000_FFFF_FFFF);
        end
        r.sum = res[31:0];
        r.ovf = (res > 64'sd2147483647) || (res < -64'sd2147483648);
        r.due = 0;
        return r;
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] corners [4];
        corners[0] = 32'hFFFF_FFFF;
        corners[1] = 32'h7FFF_FFFF;
        corners[2] = 32'h8000_0000;
        corners[3] = 32'h0000_0000;
        if ($urandom_range(3) == 0) return corners[$urandom_range(3)];
        return $urandom;
    endfunction

    task automatic chk(input int d, input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL dut%0d %s observed=%0h expected=%0h", d, tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        for (int d = 0; d < NDUT; d++) begin
            if (vld_o[d] === 1'b1) begin
                if (sb[d].size() == 0) begin
                    chk(d, "spurious_valid", 64'(vld_o[d]), 64'd0);
                end else begin
                    e = sb[d][0];
                    chk(d, "sum", 64'(sum_w[d]), 64'(e.sum));
                    chk(d, "carry", 64'(cout_w[d]), 64'(e.carry));
                    chk(d, "overflow", 64'(ovf_w[d]), 64'(e.ovf));
                    if (d != 0 || strict0) chk(d, "latency", 64'(cyc), 64'(e.due));
                end
            end else if (d != 0 || strict0) begin
                chk(d, "valid", 64'(vld_o[d]), 64'(sb[d].size() != 0 && sb[d][0].due <= cyc));
            end
        end
    endtask

    // One clock: inputs are already applied; record handshakes, clock, update queues, check.
    task automatic step();
        bit   fire [NDUT];
        exp_t e;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            acc[d]  = (valid_i === 1'b1) && (rdy_o[d] === 1'b1) && !rst_i;
            fire[d] = (vld_o[d] === 1'b1) && ((d == 0) ? rdy_main : rdy_all) && !rst_i;
        end
        @(posedge clk);
        cyc++;
        for (int d = 0; d < NDUT; d++) begin
            if (rst_i) begin
                sb[d].delete();
            end else begin
                if (fire[d] && sb[d].size() != 0) sb[d].delete(0);
                if (acc[d]) begin
                    e     = model(op_a, op_b, carry_i, sub_i);
                    e.due = cyc + lat_of(d) - 1;
                    sb[d].push_back(e);
                end
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic c,
                            input logic s, input logic [31:0] es, input logic ec,
                            input logic eo, input string tag);
        int n;
        op_a = a; op_b = b; carry_i = c; sub_i = s;
        valid_i  = 1'b1;
        rdy_main = 1'b1;
        step();
        chk(0, {tag, "_accept"}, 64'(acc[0]), 64'd1);
        valid_i = 1'b0;
        n = 1;
        while (vld_o[0] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(0, {tag, "_latency"}, 64'(n), 64'd2);
        chk(0, {tag, "_sum"}, 64'(sum_w[0]), 64'(es));
        chk(0, {tag, "_carry"}, 64'(cout_w[0]), 64'(ec));
        chk(0, {tag, "_ovf"}, 64'(ovf_w[0]), 64'(eo));
    endtask

    task automatic stream(input int n, input int vld_pct, input int rdy_pct, input int rst_at);
        bit hold;
        hold = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!hold) begin
                valid_i = ($urandom_range(99) < vld_pct);
                op_a    = rand_operand();
                op_b    = rand_operand();
                carry_i = 1'($urandom_range(1));
                sub_i   = 1'($urandom_range(1));
            end
            rdy_main = ($urandom_range(99) < rdy_pct);
            rst_i    = (i == rst_at);
            step();
            if (i == rst_at) begin
                for (int d = 0; d < NDUT; d++) chk(d, "valid_after_reset", 64'(vld_o[d]), 64'd0);
            end
            hold = valid_i && !acc[0] && !rst_i;
        end
        rst_i = 1'b0;
    endtask

    task automatic drain();
        valid_i  = 1'b0;
        rdy_main = 1'b1;
        for (int i = 0; i < 12; i++) step();
        for (int d = 0; d < NDUT; d++) chk(d, "drained", 64'(sb[d].size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $fatal(1, "FAIL watchdog timeout");
    end

    initial begin
        total = 0; bad = 0; cyc = 0; strict0 = 1'b1;
        rst_i = 1'b1; valid_i = 1'b0; rdy_main = 1'b1; rdy_all = 1'b1;
        op_a = '0; op_b = '0; carry_i = 1'b0; sub_i = 1'b0;
        @(negedge clk);
        step();
        step();
        for (int d = 0; d < NDUT; d++) begin
            chk(d, "rst_valid", 64'(vld_o[d]), 64'd0);
            chk(d, "rst_sum", 64'(sum_w[d]), 64'd0);
            chk(d, "rst_carry", 64'(cout_w[d]), 64'd0);
            chk(d, "rst_ovf", 64'(ovf_w[d]), 64'd0);
        end
        rst_i = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) chk(d, "rst_ready", 64'(rdy_o[d]), 64'd1);

        // Directed arithmetic cases.
        send_one(32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 1'b0, "add_basic");
        send_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "add_wrap");
        send_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
        send_one(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_neg");
        send_one(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, "sub_pos");
        send_one(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
        send_one(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub_borrow");

        // Back-to-back random stream, downstream always ready.
        stream(100, 100, 100, -1);
        drain();

        // Backpressure with the pipe full.
        strict0 = 1'b0;
        rdy_main = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            op_a = rand_operand(); op_b = rand_operand();
            carry_i = 1'($urandom_range(1)); sub_i = 1'($urandom_range(1));
            step();
        end
        valid_i = 1'b1;
        op_a = rand_operand(); op_b = rand_operand();
        rdy_main = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk(0, "bp_ready", 64'(rdy_o[0]), 64'd0);
            chk(0, "bp_valid", 64'(vld_o[0]), 64'd1);
        end
        rdy_main = 1'b1;
        step();
        chk(0, "bp_release_accept", 64'(acc[0]), 64'd1);
        drain();

        // Reset in the middle of a full-rate stream.
        strict0 = 1'b1;
        stream(40, 100, 100, 20);
        drain();

        // Random bubbles and random backpressure.
        strict0 = 1'b0;
        stream(200, 70, 60, -1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
